// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared definitions for the FIFO write-port arbiter.
//   - state_e : arbiter FSM encoding (ST_IDLE = 0, ST_BURST = 1)
//   - OWNER_W : width of the owner_id output
//   - STALL_W : width of the optional stall counter (FIFO_WR_ARB_STATS_EN)
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam int OWNER_W = 3;
    localparam int STALL_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin search. Returns the first set bit of req,
//   starting at (last_owner + 1) mod NUM_REQ and wrapping upward.
//   Ports:
//     req        in  NUM_REQ  request vector
//     last_owner in  IDX_W    index of the previous owner
//     found      out 1        at least one request is set
//     idx        out IDX_W    winning index (0 when found is low)
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    localparam logic [IDX_W:0] NUM_REQ_V = (IDX_W + 1)'(NUM_REQ);

    // One spare bit so last_owner + NUM_REQ never overflows before the wrap.
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        // Offsets 1..NUM_REQ: the previous owner itself is visited last.
        for (int i = 1; i <= NUM_REQ; i++) begin
            sum = {1'b0, last_owner} + (IDX_W + 1)'(i);
            if (sum >= NUM_REQ_V) begin
                sum = sum - NUM_REQ_V;
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the write port of the 64-entry dual-clock FIFO among NUM_REQ
//   write-domain requesters. Round-robin grants of up to MAX_BURST beats;
//   the owner's data is muxed onto buf_in and writes stall on buf_full.
//
//   Handshake: req[i] is valid, held with stable req_data/req_last until
//   accepted; a beat of requester i transfers on a rising clk_w edge where
//   gnt[i] is high (gnt is the accept strobe, equal to wr_en for the owner).
//   Dropping req[owner] mid-burst abandons the burst.
//
//   Ports:
//     clk_w     in   1                write clock
//     rst       in   1                asynchronous active-high reset
//     req       in   NUM_REQ          per-requester valid
//     req_data  in   NUM_REQ*DATA_W   requester i at [i*DATA_W +: DATA_W]
//     req_last  in   NUM_REQ          final beat of the requester's burst
//     gnt       out  NUM_REQ          one-hot beat-accept strobe
//     buf_full  in   1                FIFO full flag
//     wr_en     out  1                FIFO write enable
//     buf_in    out  DATA_W           FIFO write data
//     owner_id  out  OWNER_W          current / last owner index
//     busy      out  1                FSM is in ST_BURST (state debug view)
//     stall_cnt out  STALL_W          only with FIFO_WR_ARB_STATS_EN defined:
//                                     saturating count of full-stalled cycles
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                      clk_w,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      buf_full,
    output logic                      wr_en,
    output logic [DATA_W-1:0]         buf_in,
    output logic [OWNER_W-1:0]        owner_id,
    output logic                      busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [STALL_W-1:0]        stall_cnt
`endif
);

    localparam int                IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int                BCNT_W    = $clog2(MAX_BURST) + 1;
    localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(MAX_BURST - 1);
    // Reset makes the highest index the "previous" owner so requester 0 wins first.
    localparam logic [IDX_W-1:0]  RST_LAST  = IDX_W'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_owner_q, last_owner_d;
    logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic                in_burst;
    logic                own_req;
    logic                own_last;
    logic                xfer;
    logic                burst_end;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    always_comb begin
        // rst gates the outputs directly so a write in flight is dropped
        // without waiting for the flops to clear.
        in_burst  = (state_q == ST_BURST) && !rst;
        own_req   = req[owner_q];
        own_last  = req_last[owner_q];
        xfer      = in_burst && own_req && !buf_full;
        burst_end = xfer && (own_last || (beat_cnt_q == BEAT_LAST));

        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ST_BURST;
                end
            end
            ST_BURST: begin
                if (!own_req) begin
                    // Owner withdrew: abandon and let the next requester in.
                    last_owner_d = owner_q;
                    state_d      = ST_IDLE;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                    if (burst_end) begin
                        last_owner_d = owner_q;
                        state_d      = ST_IDLE;
                    end
                end
                // buf_full with req held: everything holds, including a pending last beat.
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_w or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= RST_LAST;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign busy     = in_burst;
    assign wr_en    = xfer;
    assign gnt      = xfer ? (NUM_REQ'(1) << owner_q) : '0;
    assign buf_in   = in_burst ? req_data[int'(owner_q)*DATA_W +: DATA_W] : '0;
    assign owner_id = OWNER_W'(owner_q);

`ifdef FIFO_WR_ARB_STATS_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_burst && own_req && buf_full && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk_w or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8,
//   MAX_BURST=8). Requester i presents data i*32 + (beats accepted so far);
//   each scenario pushes the {owner, data} sequence it expects onto exp_q
//   and every observed write pops and compares. Build with
//   FIFO_WR_ARB_STATS_EN defined to also check stall_cnt.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 8;
    localparam int W         = 3 + DATA_W;

    logic                      clk_w;
    logic                      rst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        gnt;
    logic                      buf_full;
    logic                      wr_en;
    logic [DATA_W-1:0]         buf_in;
    logic [2:0]                owner_id;
    logic                      busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0]               stall_cnt;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk_w    (clk_w),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .gnt      (gnt),
        .buf_full (buf_full),
        .wr_en    (wr_en),
        .buf_in   (buf_in),
        .owner_id (owner_id),
        .busy     (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_w = 1'b0;
        forever #5 clk_w = ~clk_w;
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0]       exp_q[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 ptr [NUM_REQ];
    logic               s_wr_en;
    logic               s_busy;
    logic [NUM_REQ-1:0] s_gnt;
    logic [2:0]         s_owner;

    function automatic void push_exp(int o, int k);
        exp_q.push_back({3'(o), DATA_W'(o * 32 + k)});
    endfunction

    task automatic drive_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*DATA_W +: DATA_W] = DATA_W'(i * 32 + ptr[i]);
        end
    endtask

    // Inputs are set at the falling edge; sample 1 ns later, let the rising
    // edge happen, advance each granted requester, return at the next fall.
    task automatic tick();
        logic [W-1:0] e;
        #1;
        s_wr_en = wr_en;
        s_busy  = busy;
        s_gnt   = gnt;
        s_owner = owner_id;
        checks++;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got owner %0d data %h, required no write", owner_id, buf_in);
            end else begin
                e = exp_q.pop_front();
                if ({owner_id, buf_in} !== e) begin
                    errors++;
                    $display("FAIL write_data: got owner %0d data %h, required owner %0d data %h",
                             owner_id, buf_in, e[W-1:DATA_W], e[DATA_W-1:0]);
                end
                checks++;
                if (gnt !== (NUM_REQ'(1) << e[W-1:DATA_W])) begin
                    errors++;
                    $display("FAIL write_gnt: got %b, required %b", gnt, NUM_REQ'(1) << e[W-1:DATA_W]);
                end
            end
        end else if (gnt !== '0) begin
            errors++;
            $display("FAIL gnt_no_write: got %b, required 0000", gnt);
        end
        @(posedge clk_w);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (s_gnt[i]) ptr[i]++;
        end
        @(negedge clk_w);
        drive_data();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        req_last = '0;
        buf_full = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) ptr[i] = 0;
        drive_data();
        exp_q.delete();
        @(negedge clk_w);
        @(negedge clk_w);
        rst = 1'b0;
    endtask

    task automatic check_idle_end(string name);
        req      = '0;
        req_last = '0;
        buf_full = 1'b0;
        tick();
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got busy %b, required 0", name, s_busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d writes outstanding, required 0", name, exp_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst      = 1'b1;
        req      = '1;
        req_last = '1;
        buf_full = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) ptr[i] = 0;
        drive_data();
        @(negedge clk_w);
        @(negedge clk_w);
        #1;
        checks++;
        if ({gnt, wr_en, buf_in, busy, owner_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt %b wr_en %b buf_in %h busy %b owner %0d, required all 0",
                     gnt, wr_en, buf_in, busy, owner_id);
        end
`ifdef FIFO_WR_ARB_STATS_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %0d, required 0", stall_cnt);
        end
`endif
        @(negedge clk_w);
        req      = '0;
        req_last = '0;
        rst      = 1'b0;
    endtask

    task automatic test_basic_burst();
        do_reset();
        for (int k = 0; k < 3; k++) push_exp(0, k);
        req = 4'b0001;
        tick();
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_arb_cycle: got busy %b, required 0", s_busy);
        end
        req_last[0] = 1'b0;
        tick();
        checks++;
        if (s_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_rise: got busy %b, required 1", s_busy);
        end
        for (int c = 0; c < 10 && ptr[0] < 3; c++) begin
            req_last[0] = (ptr[0] == 2);
            tick();
        end
        check_idle_end("basic");
    endtask

    task automatic test_round_robin();
        int idle_cycles;
        do_reset();
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < MAX_BURST; k++) push_exp(g % 4, (g / 4) * MAX_BURST + k);
        end
        req         = '1;
        idle_cycles = 0;
        for (int c = 0; c < 5 * (MAX_BURST + 1); c++) begin
            tick();
            if (!s_wr_en) idle_cycles++;
        end
        checks++;
        if (idle_cycles != 5) begin
            errors++;
            $display("FAIL rr_bubbles: got %0d idle cycles, required 5", idle_cycles);
        end
        check_idle_end("rr");
    endtask

    task automatic run_stall(int id, int nbeats, int nstall, string name);
        int stall_left;
        int t;
        stall_left = nstall;
        t          = 0;
        for (int k = 0; k < nbeats; k++) push_exp(id, k);
        for (int c = 0; c < 40 && ptr[id] < nbeats; c++) begin
            req          = NUM_REQ'(1) << id;
            req_last     = '0;
            req_last[id] = (ptr[id] == nbeats - 1);
            buf_full     = (t >= 1) && (ptr[id] == nbeats - 1) && (stall_left > 0);
            tick();
            if (buf_full) begin
                stall_left--;
                checks++;
                if ({s_wr_en, s_gnt} !== '0 || s_busy !== 1'b1 || s_owner !== 3'(id)) begin
                    errors++;
                    $display("FAIL %s_hold: got wr_en %b gnt %b busy %b owner %0d, required 0 0000 1 %0d",
                             name, s_wr_en, s_gnt, s_busy, s_owner, id);
                end
            end
            t++;
        end
        checks++;
        if (ptr[id] != nbeats) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats, required %0d", name, ptr[id], nbeats);
        end
        check_idle_end(name);
    endtask

    task automatic test_stall();
        do_reset();
        run_stall(2, 3, 5, "stall");
`ifdef FIFO_WR_ARB_STATS_EN
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL stall_cnt: got %0d, required 5", stall_cnt);
        end
`endif
    endtask

    task automatic test_full_on_last();
        // Single-beat burst from requester 3: its only beat is also its last.
        run_stall(3, 1, 3, "full_last");
    endtask

    task automatic run_withdraw(logic [NUM_REQ-1:0] others, int next_id, string name);
        do_reset();
        push_exp(1, 0);
        push_exp(1, 1);
        push_exp(next_id, 0);
        req = 4'b0010;
        tick();
        for (int c = 0; c < 20 && ptr[next_id] < 1; c++) begin
            req      = others;
            req[1]   = (ptr[1] < 2);
            req_last = others;
            tick();
        end
        checks++;
        if (ptr[1] != 2) begin
            errors++;
            $display("FAIL %s_beats: got %0d beats from requester 1, required 2", name, ptr[1]);
        end
        check_idle_end(name);
    endtask

    task automatic test_withdraw();
        run_withdraw(4'b0101, 2, "withdraw_to2");
        run_withdraw(4'b1001, 3, "withdraw_to3");
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int k = 0; k < 3; k++) push_exp(0, k);
        req = 4'b0001;
        for (int c = 0; c < 10 && ptr[0] < 3; c++) tick();
        #1;
        checks++;
        if (wr_en !== 1'b1) begin
            errors++;
            $display("FAIL midrst_beat4_live: got wr_en %b, required 1", wr_en);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({wr_en, gnt, busy, buf_in} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got wr_en %b gnt %b busy %b buf_in %h, required all 0",
                     wr_en, gnt, busy, buf_in);
        end
        @(negedge clk_w);
        rst = 1'b0;
        // Beat 4 was never accepted, so requester 0 still presents data 3.
        push_exp(0, 3);
        for (int c = 0; c < 10 && ptr[0] < 4; c++) begin
            req      = '1;
            req_last = '1;
            tick();
        end
        checks++;
        if (ptr[0] != 4) begin
            errors++;
            $display("FAIL midrst_priority: got %0d beats from requester 0, required 4", ptr[0]);
        end
        check_idle_end("midrst");
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst      = 1'b1;
        req      = '0;
        req_last = '0;
        buf_full = 1'b0;
        req_data = '0;
        test_reset();
        test_basic_burst();
        test_round_robin();
        test_stall();
        test_full_on_last();
        test_withdraw();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
